// File: rtl/uart_pkg.sv
// UART register map, status bit positions and scheduler FSM states.
package uart_pkg;

   localparam logic [31:0] UART_RX_OFS     = 32'h0000_0000;
   localparam logic [31:0] UART_TX_OFS     = 32'h0000_0004;
   localparam logic [31:0] UART_RST_TX_OFS = 32'h0000_0008;
   localparam logic [31:0] UART_RST_RX_OFS = 32'h0000_000C;
   localparam logic [31:0] UART_STAT_OFS   = 32'h0000_0010;

   localparam int STAT_TX_FULL  = 3;
   localparam int STAT_TX_EMPTY = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_POLL,
      ST_POLL_WAIT,
      ST_WRITE,
      ST_WRITE_WAIT,
      ST_GAP
   } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Registered FIFO with occupancy count; a pop frees room for a same-cycle push.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_clr,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_data,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_data,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_level
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wp;
   logic [AW-1:0]    r_rp;
   logic [AW:0]      r_cnt;
   logic             w_push;
   logic             w_pop;

   assign o_full  = r_cnt[AW];
   assign o_empty = (r_cnt == '0);
   assign o_level = r_cnt;
   assign o_data  = r_mem[r_rp];

   // Clear wins over both push and pop.
   assign w_pop  = i_pop && !o_empty && !i_clr;
   assign w_push = i_push && !i_clr && (!o_full || w_pop);

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wp] <= i_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
      end else if (i_clr) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_push) begin
            r_wp <= r_wp + 1'b1;
         end
         if (w_pop) begin
            r_rp <= r_rp + 1'b1;
         end
         unique case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_sched.sv
// Bus master draining a byte FIFO into the UART TX_DATA register,
// polling STAT until the transmitter is free and pacing writes with a gap.
module uart_tx_sched
   import uart_pkg::*;
#(
   parameter int          DEPTH      = 8,
   parameter logic [31:0] UART_BASE  = 32'h3000_0000,
   parameter int          GAP_CYCLES = 4,
   parameter int          TIMEOUT    = 255
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_push,
   input  logic [7:0]               i_push_data,
   output logic                     o_full,
   output logic [$clog2(DEPTH):0]   o_level,
   input  logic                     i_flush,
   output logic                     o_wb_valid,
   output logic [31:0]              o_wb_adr,
   output logic                     o_wb_we,
   output logic [31:0]              o_wb_dat,
   output logic [3:0]               o_wb_sel,
   input  logic                     i_wb_ack,
   input  logic [31:0]              i_wb_dat,
   output logic                     o_busy,
   output logic                     o_overflow,
   output logic                     o_timeout
);

   localparam logic [7:0] TO_LAST  = 8'(TIMEOUT - 1);
   localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

   tx_state_t   r_state;
   logic        r_valid;
   logic        r_we;
   logic [31:0] r_adr;
   logic [31:0] r_dat;
   logic [7:0]  r_tcnt;
   logic [7:0]  r_gcnt;
   logic        r_overflow;
   logic        r_timeout;
   logic        r_drop;

   logic [7:0]  w_head;
   logic        w_full;
   logic        w_empty;
   logic        w_wait;
   logic        w_to;
   logic        w_pop;
   logic        w_tx_busy;
   logic        w_unused;

   assign w_tx_busy = i_wb_dat[STAT_TX_FULL];
   assign w_unused  = ^{i_wb_dat[31:STAT_TX_FULL+1],
                        i_wb_dat[STAT_TX_FULL-1:0]};

   assign w_wait = (r_state == ST_POLL_WAIT)
                || (r_state == ST_WRITE_WAIT);
   assign w_to   = w_wait && !i_wb_ack && (r_tcnt == TO_LAST);
   // A write caught by a flush still completes but must not consume a byte.
   assign w_pop  = (r_state == ST_WRITE_WAIT) && i_wb_ack
                && !i_flush && !r_drop;

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_clr   (i_flush),
      .i_push  (i_push),
      .i_data  (i_push_data),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_level (o_level)
   );

   assign o_full     = w_full;
   assign o_wb_valid = r_valid;
   assign o_wb_adr   = r_adr;
   assign o_wb_we    = r_we;
   assign o_wb_dat   = r_dat;
   assign o_wb_sel   = 4'hF;
   assign o_overflow = r_overflow;
   assign o_timeout  = r_timeout;
   assign o_busy     = (r_state != ST_IDLE) || !w_empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_overflow <= 1'b0;
         r_timeout  <= 1'b0;
      end else if (i_flush) begin
         r_overflow <= 1'b0;
         r_timeout  <= 1'b0;
      end else begin
         if (i_push && w_full && !w_pop) begin
            r_overflow <= 1'b1;
         end
         if (w_to) begin
            r_timeout <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_valid <= 1'b0;
         r_we    <= 1'b0;
         r_adr   <= '0;
         r_dat   <= '0;
         r_tcnt  <= '0;
         r_gcnt  <= '0;
         r_drop  <= 1'b0;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               if (!w_empty) begin
                  r_state <= ST_POLL;
               end
            end
            ST_POLL: begin
               if (w_empty || i_flush) begin
                  r_state <= ST_IDLE;
               end else begin
                  r_valid <= 1'b1;
                  r_we    <= 1'b0;
                  r_adr   <= UART_BASE + UART_STAT_OFS;
                  r_dat   <= '0;
                  r_tcnt  <= '0;
                  r_state <= ST_POLL_WAIT;
               end
            end
            ST_POLL_WAIT: begin
               if (i_wb_ack) begin
                  r_valid <= 1'b0;
                  if (w_tx_busy) begin
                     r_state <= ST_POLL;
                  end else if (w_empty || i_flush) begin
                     r_state <= ST_IDLE;
                  end else begin
                     r_state <= ST_WRITE;
                  end
               end else if (w_to) begin
                  r_valid <= 1'b0;
                  r_gcnt  <= '0;
                  r_state <= ST_GAP;
               end else begin
                  r_tcnt <= r_tcnt + 8'd1;
               end
            end
            ST_WRITE: begin
               if (i_flush) begin
                  r_state <= ST_IDLE;
               end else begin
                  r_valid <= 1'b1;
                  r_we    <= 1'b1;
                  r_adr   <= UART_BASE + UART_TX_OFS;
                  r_dat   <= {24'h0, w_head};
                  r_tcnt  <= '0;
                  r_state <= ST_WRITE_WAIT;
               end
            end
            ST_WRITE_WAIT: begin
               if (i_flush) begin
                  r_drop <= 1'b1;
               end
               if (i_wb_ack || w_to) begin
                  r_valid <= 1'b0;
                  r_gcnt  <= '0;
                  r_state <= ST_GAP;
               end else begin
                  r_tcnt <= r_tcnt + 8'd1;
               end
            end
            ST_GAP: begin
               if (r_gcnt == GAP_LAST) begin
                  r_drop <= 1'b0;
                  if (r_drop || w_empty || i_flush) begin
                     r_state <= ST_IDLE;
                  end else begin
                     r_state <= ST_POLL;
                  end
               end else begin
                  r_gcnt <= r_gcnt + 8'd1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: bus slave model plus a queue-based reference model.
module tb_uart_tx_sched;

   localparam int          DEPTH = 8;
   localparam logic [31:0] BASE  = 32'h3000_0000;
   localparam int          GAP   = 4;
   localparam int          TMO   = 255;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_push = 1'b0;
   logic [7:0]  i_push_data = 8'h0;
   logic        i_flush = 1'b0;
   logic        i_wb_ack = 1'b0;
   logic [31:0] i_wb_dat = 32'h0;
   logic        o_full;
   logic [3:0]  o_level;
   logic        o_wb_valid;
   logic [31:0] o_wb_adr;
   logic        o_wb_we;
   logic [31:0] o_wb_dat;
   logic [3:0]  o_wb_sel;
   logic        o_busy;
   logic        o_overflow;
   logic        o_timeout;

   uart_tx_sched #(
      .DEPTH      (DEPTH),
      .UART_BASE  (BASE),
      .GAP_CYCLES (GAP),
      .TIMEOUT    (TMO)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_push      (i_push),
      .i_push_data (i_push_data),
      .o_full      (o_full),
      .o_level     (o_level),
      .i_flush     (i_flush),
      .o_wb_valid  (o_wb_valid),
      .o_wb_adr    (o_wb_adr),
      .o_wb_we     (o_wb_we),
      .o_wb_dat    (o_wb_dat),
      .o_wb_sel    (o_wb_sel),
      .i_wb_ack    (i_wb_ack),
      .i_wb_dat    (i_wb_dat),
      .o_busy      (o_busy),
      .o_overflow  (o_overflow),
      .o_timeout   (o_timeout)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: queued bytes, accepted stream, completed writes.
   logic [7:0]  mq[$];
   logic [7:0]  acc[$];
   logic [7:0]  done[$];
   bit          m_ovf, m_to;
   bit          in_req, exp_low, wr_drop, stat_ok;
   logic [31:0] c_adr, c_dat;
   logic        c_we;
   int          rlen, cur_lat;
   int          cyc = 0;
   int          last_wr_end = -1000;
   int          stat_reads = 0;
   int          wr_tries = 0;

   bit          s_stall = 0;
   bit          s_wr_noack = 0;
   bit          s_rand = 0;
   int          s_lat = 1;
   int          s_busy = 0;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      bit          ack;
      bit          pop;
      bit          busy;
      logic [31:0] rd;
      ack = 0;
      pop = 0;
      rd  = 32'h0;
      cyc++;
      if (!rst_n) begin
         mq.delete();
         m_ovf   = 0;
         m_to    = 0;
         in_req  = 0;
         exp_low = 0;
         wr_drop = 0;
         stat_ok = 0;
      end else begin
         check("level", 32'(o_level), 32'(mq.size()));
         check("full", 32'(o_full), 32'(mq.size() == DEPTH));
         check("overflow", 32'(o_overflow), 32'(m_ovf));
         check("timeout", 32'(o_timeout), 32'(m_to));
         check("sel", 32'(o_wb_sel), 32'hF);
         if (exp_low) begin
            check("valid_drop", 32'(o_wb_valid), 32'h0);
            exp_low = 0;
         end
         if (o_wb_valid) begin
            if (!in_req) begin
               in_req  = 1;
               rlen    = 0;
               c_adr   = o_wb_adr;
               c_we    = o_wb_we;
               c_dat   = o_wb_dat;
               cur_lat = s_rand ? int'($urandom_range(0, 3)) : s_lat;
               if (o_wb_we) begin
                  wr_tries++;
                  wr_drop = 0;
                  check("wr_adr", o_wb_adr, BASE + 32'h4);
                  check("wr_after_stat", 32'(stat_ok), 32'h1);
                  check("wr_gap", 32'(cyc - last_wr_end - 1 >= GAP), 32'h1);
                  check("wr_nonempty", 32'(mq.size() != 0), 32'h1);
                  if (mq.size() != 0) begin
                     check("wr_dat", o_wb_dat, {24'h0, mq[0]});
                  end
                  stat_ok = 0;
               end else begin
                  check("rd_adr", o_wb_adr, BASE + 32'h10);
               end
            end else begin
               check("hold_adr", o_wb_adr, c_adr);
               check("hold_we", 32'(o_wb_we), 32'(c_we));
               check("hold_dat", o_wb_dat, c_dat);
            end
            rlen++;
            ack = !s_stall && !(c_we && s_wr_noack) && (rlen > cur_lat);
            if (ack) begin
               in_req  = 0;
               exp_low = 1;
               if (c_we) begin
                  done.push_back(c_dat[7:0]);
                  last_wr_end = cyc;
                  pop = !i_flush && !wr_drop;
                  rd  = $urandom;
               end else begin
                  stat_reads++;
                  if (s_rand) begin
                     busy = ($urandom_range(0, 3) == 0);
                     rd   = $urandom;
                     rd[3] = busy;
                  end else begin
                     busy = (s_busy > 0);
                     if (busy) s_busy--;
                     rd = busy ? 32'h9 : 32'h5;
                  end
                  stat_ok = !busy;
               end
            end else if (rlen == TMO) begin
               in_req  = 0;
               exp_low = 1;
               m_to    = 1;
            end
            if (i_flush && c_we) wr_drop = 1;
         end else begin
            check("req_open", 32'(in_req), 32'h0);
         end
         if (pop) void'(mq.pop_front());
         if (i_flush) begin
            mq.delete();
            m_ovf = 0;
            m_to  = 0;
         end else if (i_push) begin
            if (mq.size() < DEPTH) begin
               mq.push_back(i_push_data);
               acc.push_back(i_push_data);
            end else begin
               m_ovf = 1;
            end
         end
      end
      i_wb_ack = ack;
      i_wb_dat = rd;
   end

   task automatic do_push(input logic [7:0] b);
      i_push      = 1'b1;
      i_push_data = b;
      @(posedge clk); #1;
      i_push = 1'b0;
   endtask

   task automatic do_flush();
      i_flush = 1'b1;
      @(posedge clk); #1;
      i_flush = 1'b0;
   endtask

   task automatic clear_logs();
      acc.delete();
      done.delete();
      stat_reads = 0;
      wr_tries   = 0;
   endtask

   task automatic wait_idle(input int max_cyc, input string tag);
      int n = 0;
      while (o_busy === 1'b1 && n < max_cyc) begin
         @(negedge clk);
         n++;
      end
      check(tag, 32'(o_busy), 32'h0);
      @(posedge clk); #1;
   endtask

   task automatic check_stream(input string tag);
      check({tag, "_n"}, 32'(done.size()), 32'(acc.size()));
      for (int i = 0; i < done.size() && i < acc.size(); i++) begin
         check(tag, 32'(done[i]), 32'(acc[i]));
      end
   endtask

   initial begin
      logic [7:0] b;
      int         n;

      rst_n = 1'b0;
      #12;
      check("rst_valid", 32'(o_wb_valid), 32'h0);
      check("rst_adr", o_wb_adr, 32'h0);
      check("rst_we", 32'(o_wb_we), 32'h0);
      check("rst_dat", o_wb_dat, 32'h0);
      check("rst_level", 32'(o_level), 32'h0);
      check("rst_full", 32'(o_full), 32'h0);
      check("rst_busy", 32'(o_busy), 32'h0);
      check("rst_ovf", 32'(o_overflow), 32'h0);
      check("rst_to", 32'(o_timeout), 32'h0);
      check("rst_sel", 32'(o_wb_sel), 32'hF);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      clear_logs();
      s_lat = 1;
      do_push(8'h41);
      check("basic_busy", 32'(o_busy), 32'h1);
      check("basic_lvl1", 32'(o_level), 32'h1);
      wait_idle(200, "basic_idle");
      check("basic_reads", 32'(stat_reads), 32'h1);
      check("basic_n", 32'(done.size()), 32'h1);
      if (done.size() > 0) check("basic_dat", 32'(done[0]), 32'h41);
      check("basic_lvl0", 32'(o_level), 32'h0);

      clear_logs();
      s_busy = 3;
      b = 8'($urandom);
      do_push(b);
      wait_idle(300, "poll_idle");
      check("poll_reads", 32'(stat_reads), 32'h4);
      check_stream("poll_stream");

      clear_logs();
      s_rand = 1;
      for (int i = 0; i < 8; i++) do_push(8'h10 + 8'(i));
      wait_idle(2000, "order_idle");
      check_stream("order_stream");
      for (int i = 0; i < done.size(); i++) begin
         check("order_val", 32'(done[i]), 32'h10 + 32'(i));
      end
      check("order_reads", 32'(stat_reads >= 8), 32'h1);

      clear_logs();
      for (int i = 0; i < 300; i++) begin
         i_push      = ($urandom_range(0, 2) == 0);
         i_push_data = 8'($urandom);
         @(posedge clk); #1;
      end
      i_push = 1'b0;
      wait_idle(5000, "rand_idle");
      check_stream("rand_stream");
      do_flush();

      clear_logs();
      s_rand  = 0;
      s_lat   = 1;
      s_stall = 1;
      for (int i = 0; i < 10; i++) do_push(8'($urandom));
      check("full_level", 32'(o_level), 32'h8);
      check("full_flag", 32'(o_full), 32'h1);
      check("full_ovf", 32'(o_overflow), 32'h1);
      s_stall = 0;
      wait_idle(1000, "full_idle");
      check("full_sent", 32'(done.size()), 32'h8);
      check_stream("full_stream");
      check("full_ovf_hold", 32'(o_overflow), 32'h1);
      do_flush();
      check("full_ovf_clr", 32'(o_overflow), 32'h0);

      clear_logs();
      s_wr_noack = 1;
      b = 8'($urandom);
      do_push(b);
      n = 0;
      while (o_timeout !== 1'b1 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check("to_set", 32'(o_timeout), 32'h1);
      check("to_valid", 32'(o_wb_valid), 32'h0);
      @(posedge clk); #1;
      s_wr_noack = 0;
      wait_idle(1000, "to_idle");
      check("to_tries", 32'(wr_tries), 32'h2);
      check_stream("to_stream");
      do_flush();
      check("to_clr", 32'(o_timeout), 32'h0);

      clear_logs();
      s_lat = 6;
      for (int i = 0; i < 5; i++) do_push(8'($urandom));
      n = 0;
      while (!(o_wb_valid === 1'b1 && o_wb_we === 1'b1) && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("fl_inflight", 32'(o_wb_valid && o_wb_we), 32'h1);
      @(posedge clk); #1;
      do_flush();
      check("fl_level", 32'(o_level), 32'h0);
      wait_idle(300, "fl_idle");
      check("fl_done", 32'(done.size()), 32'h1);
      if (done.size() > 0 && acc.size() > 0) begin
         check("fl_dat", 32'(done[0]), 32'(acc[0]));
      end
      check("fl_level_end", 32'(o_level), 32'h0);

      clear_logs();
      s_lat   = 1;
      s_stall = 1;
      do_push(8'($urandom));
      n = 0;
      while (!(o_wb_valid === 1'b1 && o_wb_we === 1'b0) && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("rs_polling", 32'(o_wb_valid), 32'h1);
      #2;
      rst_n = 1'b0;
      #1;
      check("rs_valid", 32'(o_wb_valid), 32'h0);
      check("rs_level", 32'(o_level), 32'h0);
      check("rs_busy", 32'(o_busy), 32'h0);
      check("rs_adr", o_wb_adr, 32'h0);
      check("rs_flags", 32'({o_overflow, o_timeout, o_full}), 32'h0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n   = 1'b1;
      s_stall = 0;
      @(posedge clk); #1;
      check("rs_idle", 32'(o_busy), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
Wishbone master that drains a small byte FIFO into the UART control block's TX_DATA register. It sits between a byte producer (firmware-side streamer or a debug/trace source) and the UART register port. It polls STAT_REG until the transmitter is idle, writes one byte, then waits a guard gap before polling again. The producer therefore never has to handle UART busy status or bus handshakes.

Parameters:
DEPTH, 8, FIFO depth in bytes; power of 2, at least 2.
UART_BASE, 32'h3000_0000, base address. TX_DATA is at base+4 and STAT_REG at base+0x10.
GAP_CYCLES, 4, idle cycles after a TX_DATA write ack before the next STAT_REG poll. Covers the UART busy-flag latency.
TIMEOUT, 255, maximum cycles to wait for i_wb_ack. Valid range 1..255.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
i_push  in  1  producer write strobe
i_push_data  in  8  byte to queue
o_full  out  1  FIFO full; a push while full is dropped
o_level  out  $clog2(DEPTH)+1  current FIFO occupancy
i_flush  in  1  discard all queued bytes
o_wb_valid  out  1  bus request
o_wb_adr  out  32  bus address
o_wb_we  out  1  1 = write
o_wb_dat  out  32  write data
o_wb_sel  out  4  byte enables, always 4'hF
i_wb_ack  in  1  bus acknowledge
i_wb_dat  in  32  read data, valid in the same cycle as i_wb_ack
o_busy  out  1  FSM is not in IDLE, or FIFO is not empty
o_overflow  out  1  sticky: a push was dropped; cleared by i_flush
o_timeout  out  1  sticky: an ack timeout occurred; cleared by i_flush

Behaviour:
- Reset (asynchronous, active-low): all outputs are 0, FIFO is empty, FSM is in IDLE, counters are 0. o_wb_sel is 4'hF at all times.
- FIFO:
  - Registered FIFO. A push is accepted when i_push && !o_full.
  - A pop happens on the write-ack cycle of TX_DATA.
  - A push and a pop in the same cycle leave the level unchanged. Pointers wrap modulo DEPTH.
- FSM states: IDLE, POLL, POLL_WAIT, WRITE, WRITE_WAIT, GAP.
- IDLE -> POLL when the FIFO is non-empty.
- POLL: drive valid=1, we=0, adr=UART_BASE+0x10. Go to POLL_WAIT.
- POLL_WAIT: hold the request until i_wb_ack. On ack, deassert valid in the next cycle, then:
  - if i_wb_dat[3] (tx busy) is 1, go back to POLL;
  - otherwise go to WRITE.
- WRITE: drive valid=1, we=1, adr=UART_BASE+4, dat={24'h0, FIFO head}. Go to WRITE_WAIT.
- WRITE_WAIT: on ack, pop the FIFO and go to GAP.
- GAP: count GAP_CYCLES cycles, then go to POLL if the FIFO is non-empty, otherwise IDLE.
- Bus handshake:
  - Address, we and data are stable from valid rise until the ack cycle.
  - Valid deasserts in the cycle after ack is sampled. The slave keeps acking while valid is held, so at most one ack is consumed per request.
  - Minimum one idle cycle between requests.
- Timeout:
  - An 8-bit counter runs in each *_WAIT state. When it reaches TIMEOUT: deassert valid, set o_timeout, go to GAP.
  - On a timeout in WRITE_WAIT the byte is not popped and is retried.
- Flush:
  - Clears the FIFO pointers and the sticky flags in the same cycle.
  - A bus request in flight still completes, but the pop is suppressed on that cycle.
  - The FSM then ends in IDLE.
- Simultaneous events:
  - i_flush has priority over i_push in the same cycle; the pushed byte is discarded.
  - A push in the same cycle as a pop is accepted even when full, because occupancy never exceeds DEPTH.

Decomposition:
- Package uart_pkg:
  - UART register offsets: RX 0x0, TX 0x4, RST_TX 0x8, RST_RX 0xC, STAT 0x10;
  - status bit indices: TX_FULL=3, TX_EMPTY=2;
  - FSM state enum.
- Sub-module sync_fifo (parameters WIDTH, DEPTH) provides push/pop/full/empty/level. The FSM, timeout logic and bus driver stay in the top module.

Test Plan:
- Basic send: push 8'h41, with a slave model that acks after 1 cycle and STAT=0x5 -> one STAT read, then a write to 0x3000_0004 with dat 0x41. o_level goes 1 -> 0, o_busy falls after GAP.
- Busy polling: STAT returns 0x9 (bit 3 set) for 3 polls, then 0x5 -> exactly 4 STAT reads before the TX_DATA write, and no write while bit 3 = 1.
- Full and overflow, DEPTH=8: with the slave stalled (never acks), push 10 bytes -> o_full=1 after 8 pushes, o_overflow=1, o_level=8.
- Ordering: push 0x10..0x17 back-to-back -> TX_DATA writes appear in order 0x10..0x17, each preceded by at least one STAT read and separated by at least GAP_CYCLES idle cycles.
- Timeout: the slave never acks the write -> o_timeout=1 after TIMEOUT cycles, valid drops, and the same byte is retried after GAP.
- Flush and reset: assert i_flush during WRITE_WAIT with 5 bytes queued -> the write completes, o_level=0, FSM returns to IDLE. Assert rst_n=0 mid-POLL_WAIT -> o_wb_valid=0 immediately, all flags cleared.
